// File: rtl/xilinx_status_led_ctrl.sv
// rtl/xilinx_status_led_ctrl.sv - multi-channel status LED bank with optional exit-code display (STATUS_LED_EXIT_DISPLAY_EN)
module xilinx_status_led_ctrl #(
    parameter int NUM_LEDS   = 3,
    parameter int PRESCALE_W = 27,
    parameter int PWM_W      = 8,
    parameter int PULSE_CYC  = 2**24
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [2*NUM_LEDS-1:0]     led_mode_i,
    input  logic [PWM_W*NUM_LEDS-1:0] pwm_duty_i,
    input  logic                      exit_valid_i,
    input  logic [31:0]               exit_value_i,
    output logic [NUM_LEDS-1:0]       led_o,
    output logic                      heartbeat_o,
    output logic                      exit_busy_o
);

    localparam logic [1:0] MODE_OFF   = 2'b00;
    localparam logic [1:0] MODE_ON    = 2'b01;
    localparam logic [1:0] MODE_BLINK = 2'b10;
    localparam logic [1:0] MODE_PWM   = 2'b11;

    logic [PRESCALE_W-1:0] r_prescale;
    logic [PWM_W-1:0]      r_pwm_cnt;
    logic [NUM_LEDS-1:0]   r_led;
    logic [NUM_LEDS-1:0]   w_led_norm;

    // Free-running heartbeat prescaler and PWM counter; both keep running during the exit display
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_prescale <= '0;
            r_pwm_cnt  <= '0;
        end else begin
            r_prescale <= r_prescale + 1'b1;
            r_pwm_cnt  <= r_pwm_cnt + 1'b1;
        end
    end

    assign heartbeat_o = r_prescale[PRESCALE_W-1];

    // Per-channel drive value selected by the channel's mode field
    always_comb begin
        w_led_norm = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            case (led_mode_i[2*i +: 2])
                MODE_OFF:   w_led_norm[i] = 1'b0;
                MODE_ON:    w_led_norm[i] = 1'b1;
                MODE_BLINK: w_led_norm[i] = r_prescale[PRESCALE_W-1];
                MODE_PWM:   w_led_norm[i] = (r_pwm_cnt < pwm_duty_i[PWM_W*i +: PWM_W]);
                default:    w_led_norm[i] = 1'b0;
            endcase
        end
    end

`ifdef STATUS_LED_EXIT_DISPLAY_EN

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_OK        = 3'd1,
        S_PULSE_ON  = 3'd2,
        S_PULSE_OFF = 3'd3,
        S_GAP       = 3'd4
    } exit_state_t;

    localparam int                  TIMER_W    = $clog2(4*PULSE_CYC);
    localparam logic [TIMER_W-1:0]  PULSE_LAST = TIMER_W'(PULSE_CYC - 1);
    localparam logic [TIMER_W-1:0]  GAP_LAST   = TIMER_W'(4*PULSE_CYC - 1);
    localparam logic [NUM_LEDS-1:0] LED_OK     = NUM_LEDS'(1);
    localparam logic [NUM_LEDS-1:0] LED_ERR    = NUM_LEDS'(1) << (NUM_LEDS - 1);

    exit_state_t        r_state;
    logic [TIMER_W-1:0] r_timer;
    logic [3:0]         r_code;
    logic [3:0]         r_pulse_cnt;
    logic               r_busy;
    logic               r_exit_prev;
    logic               w_exit_edge;
    logic               w_unused;

    // Prev-sample register resets to 0, so a level already high out of reset counts as an edge
    assign w_exit_edge = exit_valid_i & ~r_exit_prev;
    assign w_unused    = ^exit_value_i[31:4];

    // Exit-code FSM: capture once per reset, then blink the code forever on the error LED
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= S_IDLE;
            r_timer     <= '0;
            r_code      <= '0;
            r_pulse_cnt <= '0;
            r_busy      <= 1'b0;
            r_exit_prev <= 1'b0;
        end else begin
            r_exit_prev <= exit_valid_i;
            case (r_state)
                S_IDLE: begin
                    if (w_exit_edge) begin
                        r_code      <= exit_value_i[3:0];
                        r_pulse_cnt <= exit_value_i[3:0];
                        r_timer     <= '0;
                        r_busy      <= 1'b1;
                        r_state     <= (exit_value_i[3:0] == 4'd0) ? S_OK : S_PULSE_ON;
                    end
                end
                S_OK: begin
                    r_state <= S_OK;
                end
                S_PULSE_ON: begin
                    if (r_timer == PULSE_LAST) begin
                        r_timer     <= '0;
                        r_pulse_cnt <= r_pulse_cnt - 4'd1;
                        r_state     <= S_PULSE_OFF;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_PULSE_OFF: begin
                    if (r_timer == PULSE_LAST) begin
                        r_timer <= '0;
                        r_state <= (r_pulse_cnt != 4'd0) ? S_PULSE_ON : S_GAP;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_GAP: begin
                    if (r_timer == GAP_LAST) begin
                        r_timer     <= '0;
                        r_pulse_cnt <= r_code;
                        r_state     <= S_PULSE_ON;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_timer <= '0;
                end
            endcase
        end
    end

    // LED register: the exit display overrides normal modes one cycle after the FSM leaves IDLE
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_led <= '0;
        end else if (r_state == S_OK) begin
            r_led <= LED_OK;
        end else if (r_state == S_PULSE_ON) begin
            r_led <= LED_ERR;
        end else if (r_state != S_IDLE) begin
            r_led <= '0;
        end else begin
            r_led <= w_led_norm;
        end
    end

    assign exit_busy_o = r_busy;

`else

    logic w_unused;

    assign w_unused = ^{exit_valid_i, exit_value_i};

    // LED register driven purely by the per-channel modes
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_led <= '0;
        end else begin
            r_led <= w_led_norm;
        end
    end

    assign exit_busy_o = 1'b0;

`endif

    assign led_o = r_led;

endmodule
